// File: rtl/in_port_sync.sv
// Input port with a multi-stage pin synchronizer, a load-gated capture register
// and a sticky, maskable pin-change detector that stays quiet during post-reset warm-up.
module in_port_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_port_pins,
  input  logic             load_en,
  output logic [WIDTH-1:0] in_port_out,
  input  logic             mask_load,
  input  logic [WIDTH-1:0] mask_data,
  input  logic             pc_ack,
  output logic [WIDTH-1:0] pc_bits,
  output logic             pc_flag
);

  typedef enum logic {WARM, RUN} state_t;

  localparam logic [2:0] WARM_EDGES = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] chg;
  state_t           state, state_nxt;
  logic [2:0]       warm_cnt, warm_cnt_nxt;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Until the chain has flushed the reset zeros, sync_out vs prev differences are
  // artefacts of reset, not real pin activity.
  assign chg     = (state == RUN) ? ((sync_out ^ prev) & mask) : '0;
  assign pc_flag = |pc_bits;

  always_comb begin
    state_nxt    = state;
    warm_cnt_nxt = warm_cnt;
    if (state == WARM) begin
      warm_cnt_nxt = warm_cnt + 3'd1;
      if (warm_cnt_nxt == WARM_EDGES) state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WARM;
      warm_cnt <= '0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      prev        <= '0;
      in_port_out <= '0;
      mask        <= '0;
      pc_bits     <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port_pins};
      prev   <= sync_out;
      if (load_en)   in_port_out <= sync_out;
      if (mask_load) mask        <= mask_data;
      // A fresh change wins over an ack landing on the same edge.
      pc_bits <= (pc_bits & ~{WIDTH{pc_ack}}) | chg;
    end
  end

endmodule

// File: tb/tb_in_port_sync.sv
// Directed bench for in_port_sync (WIDTH=8, SYNC_STAGES=2); expected values are hand-derived.
module tb_in_port_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_port_pins;
  logic       load_en;
  logic [7:0] in_port_out;
  logic       mask_load;
  logic [7:0] mask_data;
  logic       pc_ack;
  logic [7:0] pc_bits;
  logic       pc_flag;

  int total = 0;
  int bad   = 0;

  in_port_sync #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_port_pins(in_port_pins), .load_en(load_en),
    .in_port_out(in_port_out), .mask_load(mask_load), .mask_data(mask_data),
    .pc_ack(pc_ack), .pc_bits(pc_bits), .pc_flag(pc_flag)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_port_pins = 8'h00; load_en = 1'b1;
    mask_load = 1'b1; mask_data = 8'hFF; pc_ack = 1'b1;
    tick(2);
    total++; if (in_port_out !== 8'h00) begin bad++; $display("FAIL rst_out got=%h exp=00", in_port_out); end
    total++; if (pc_bits !== 8'h00) begin bad++; $display("FAIL rst_pc_bits got=%h exp=00", pc_bits); end
    total++; if (pc_flag !== 1'b0) begin bad++; $display("FAIL rst_flag got=%b exp=0", pc_flag); end
    mask_load = 1'b0; pc_ack = 1'b0;
  endtask

  // Pins already at 0xFF when reset drops; warm-up must hide the 0->FF ramp.
  task automatic test_warmup();
    in_port_pins = 8'hFF;
    tick(1);
    rst = 1'b0; mask_load = 1'b1; mask_data = 8'hFF; load_en = 1'b1;
    tick(1);
    mask_load = 1'b0;
    for (int e = 2; e <= 8; e++) begin
      tick(1);
      total++; if (pc_flag !== 1'b0) begin bad++; $display("FAIL warm_flag edge=%0d got=%b exp=0", e, pc_flag); end
      if (e == 3) begin
        total++; if (in_port_out !== 8'hFF) begin bad++; $display("FAIL warm_load got=%h exp=FF", in_port_out); end
      end
    end
  endtask

  task automatic test_capture();
    in_port_pins = 8'hA5; load_en = 1'b1;
    tick(1);
    total++; if (in_port_out !== 8'hFF) begin bad++; $display("FAIL cap_e1 got=%h exp=FF", in_port_out); end
    tick(1);
    total++; if (in_port_out !== 8'hFF) begin bad++; $display("FAIL cap_e2 got=%h exp=FF", in_port_out); end
    tick(1);
    total++; if (in_port_out !== 8'hA5) begin bad++; $display("FAIL cap_e3 got=%h exp=A5", in_port_out); end
    total++; if (pc_bits !== 8'h5A) begin bad++; $display("FAIL cap_pc got=%h exp=5A", pc_bits); end
    total++; if (pc_flag !== 1'b1) begin bad++; $display("FAIL cap_flag got=%b exp=1", pc_flag); end
    load_en = 1'b0; in_port_pins = 8'h00;
    tick(3);
    total++; if (in_port_out !== 8'hA5) begin bad++; $display("FAIL cap_hold got=%h exp=A5", in_port_out); end
    total++; if (pc_bits !== 8'hFF) begin bad++; $display("FAIL cap_accum got=%h exp=FF", pc_bits); end
    pc_ack = 1'b1;
    tick(1);
    pc_ack = 1'b0;
    total++; if (pc_bits !== 8'h00) begin bad++; $display("FAIL ack_clr got=%h exp=00", pc_bits); end
    total++; if (pc_flag !== 1'b0) begin bad++; $display("FAIL ack_flag got=%b exp=0", pc_flag); end
  endtask

  task automatic test_masked_change();
    mask_load = 1'b1; mask_data = 8'h0F;
    tick(1);
    mask_load = 1'b0; in_port_pins = 8'h3C;
    tick(3);
    total++; if (pc_bits !== 8'h0C) begin bad++; $display("FAIL mask_pc got=%h exp=0C", pc_bits); end
    total++; if (pc_flag !== 1'b1) begin bad++; $display("FAIL mask_flag got=%b exp=1", pc_flag); end
    total++; if (pc_bits[5:4] !== 2'b00) begin bad++; $display("FAIL mask_hi got=%b exp=00", pc_bits[5:4]); end
    tick(1);
    total++; if (pc_bits !== 8'h0C) begin bad++; $display("FAIL mask_sticky got=%h exp=0C", pc_bits); end
  endtask

  task automatic test_ack_collision();
    pc_ack = 1'b1;
    tick(1);
    pc_ack = 1'b0; in_port_pins = 8'h38;
    tick(3);
    total++; if (pc_bits !== 8'h04) begin bad++; $display("FAIL coll_pre got=%h exp=04", pc_bits); end
    in_port_pins = 8'h39;
    tick(2);
    total++; if (pc_bits !== 8'h04) begin bad++; $display("FAIL coll_mid got=%h exp=04", pc_bits); end
    pc_ack = 1'b1;
    tick(1);
    pc_ack = 1'b0;
    total++; if (pc_bits !== 8'h01) begin bad++; $display("FAIL coll got=%h exp=01", pc_bits); end
  endtask

  task automatic test_mask_race();
    mask_load = 1'b1; mask_data = 8'h80; pc_ack = 1'b1;
    tick(1);
    mask_load = 1'b0; pc_ack = 1'b0; in_port_pins = 8'hB9;
    tick(2);
    total++; if (pc_bits !== 8'h00) begin bad++; $display("FAIL race_pre got=%h exp=00", pc_bits); end
    mask_load = 1'b1; mask_data = 8'h00;
    tick(1);
    mask_load = 1'b0;
    total++; if (pc_bits[7] !== 1'b1) begin bad++; $display("FAIL race_b7 got=%b exp=1", pc_bits[7]); end
    in_port_pins = 8'h39;
    tick(3);
    total++; if (pc_bits !== 8'h80) begin bad++; $display("FAIL race_sticky got=%h exp=80", pc_bits); end
  endtask

  task automatic test_mid_reset();
    mask_load = 1'b1; mask_data = 8'hFF; pc_ack = 1'b1;
    tick(1);
    mask_load = 1'b0; pc_ack = 1'b0; load_en = 1'b1; in_port_pins = 8'hA5;
    tick(3);
    in_port_pins = 8'h5A;
    tick(3);
    total++; if (pc_bits !== 8'hFF) begin bad++; $display("FAIL mr_pre_pc got=%h exp=FF", pc_bits); end
    total++; if (in_port_out !== 8'h5A) begin bad++; $display("FAIL mr_pre_out got=%h exp=5A", in_port_out); end
    load_en = 1'b0; rst = 1'b1;
    tick(1);
    rst = 1'b0;
    total++; if (pc_bits !== 8'h00) begin bad++; $display("FAIL mr_pc got=%h exp=00", pc_bits); end
    total++; if (in_port_out !== 8'h00) begin bad++; $display("FAIL mr_out got=%h exp=00", in_port_out); end
    total++; if (pc_flag !== 1'b0) begin bad++; $display("FAIL mr_flag got=%b exp=0", pc_flag); end
    // Mask was reset to 0; reload during WARM so suppression alone keeps the flag low.
    mask_load = 1'b1; mask_data = 8'hFF;
    tick(1);
    mask_load = 1'b0;
    for (int e = 2; e <= 6; e++) begin
      tick(1);
      total++; if (pc_flag !== 1'b0) begin bad++; $display("FAIL mr_warm edge=%0d got=%b exp=0", e, pc_flag); end
    end
    in_port_pins = 8'h5B;
    tick(3);
    total++; if (pc_bits !== 8'h01) begin bad++; $display("FAIL mr_run got=%h exp=01", pc_bits); end
  endtask

  task automatic test_short_toggle();
    pc_ack = 1'b1;
    tick(1);
    pc_ack = 1'b0; in_port_pins = 8'h5F;
    tick(1);
    in_port_pins = 8'h5B;
    tick(4);
    total++; if (pc_bits !== 8'h04) begin bad++; $display("FAIL pulse got=%h exp=04", pc_bits); end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_capture();
    test_masked_change();
    test_ack_collision();
    test_mask_race();
    test_mid_reset();
    test_short_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
